uart_rx: RTL and testbench

//  UART receiver: the receive end of the team's UART link. Oversamples the serial

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_baud_tick.sv | 30 +++
 rtl/uart_rx.sv | 150 +++++++++++++++
 tb/tb_uart_rx.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Parity encoding, FSM states and parity helpers shared by the UART receiver and transmitter.
// No logic of its own; both ends decode parity_type the same way.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_state_t;

  function automatic logic has_parity(input logic [1:0] ptype);
    return (ptype == PAR_ODD) || (ptype == PAR_EVEN);
  endfunction

  // xor_all is the XOR over payload and received parity bit
  function automatic logic parity_mismatch(input logic [1:0] ptype, input logic xor_all);
    if (ptype == PAR_ODD)  return ~xor_all;
    if (ptype == PAR_EVEN) return xor_all;
    return 1'b0;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Baud divider: one-cycle tick every DIV clocks, counter restartable to 0 synchronously.
// Latency: tick is combinational from the counter; restart takes effect next clock.
// Backpressure: none, free-running.
module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (restart || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled 8N1/8O1/8E1 frame recovery with parity and framing status.
// Latency: data_valid one clk after the stop-bit mid-sample, plus 2 clks of rx synchroniser.
// Backpressure: none; data_out and status hold until the next data_valid, no overrun flag.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic [1:0]           parity_type,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 rx_busy
);

  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int TW  = $clog2(OVERSAMPLE);
  localparam int BW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] HALF_TICK = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  uart_state_t          state;
  logic                 rx_meta;
  logic                 rx_s;
  logic                 tick;
  logic                 restart;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic [1:0]           ptype_q;
  logic                 par_err_q;

  // Restarting on the start edge puts every later sample a fixed tick count from it
  assign restart = (state == IDLE) && tick && !rx_s;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (restart),
    .tick    (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      rx_meta       <= 1'b1;
      rx_s          <= 1'b1;
      tick_cnt      <= '0;
      bit_cnt       <= '0;
      shift_reg     <= '0;
      ptype_q       <= PAR_NONE;
      par_err_q     <= 1'b0;
      data_out      <= '0;
      data_valid    <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      rx_busy       <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rx_s       <= rx_meta;
      data_valid <= 1'b0;
      if (tick) begin
        unique case (state)
          IDLE: begin
            if (!rx_s) begin
              state     <= START;
              ptype_q   <= parity_type;
              tick_cnt  <= '0;
              bit_cnt   <= '0;
              par_err_q <= 1'b0;
              rx_busy   <= 1'b1;
            end
          end
          START: begin
            if (tick_cnt == HALF_TICK) begin
              tick_cnt <= '0;
              if (rx_s) begin
                state   <= IDLE;
                rx_busy <= 1'b0;
              end else begin
                state <= DATA;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          DATA: begin
            if (tick_cnt == LAST_TICK) begin
              tick_cnt  <= '0;
              shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
              if (bit_cnt == LAST_BIT) begin
                state <= has_parity(ptype_q) ? PARITY : STOP;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          PARITY: begin
            if (tick_cnt == LAST_TICK) begin
              tick_cnt  <= '0;
              par_err_q <= parity_mismatch(ptype_q, ^{shift_reg, rx_s});
              state     <= STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          STOP: begin
            if (tick_cnt == LAST_TICK) begin
              tick_cnt      <= '0;
              data_out      <= shift_reg;
              data_valid    <= 1'b1;
              parity_error  <= par_err_q;
              framing_error <= ~rx_s;
              if (rx_s) begin
                state   <= IDLE;
                rx_busy <= 1'b0;
              end else begin
                state <= BREAK;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          BREAK: begin
            // A held-low line must go high before a new start edge is accepted
            if (rx_s) begin
              state   <= IDLE;
              rx_busy <= 1'b0;
            end
          end
          default: begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus randomized frames against a
// bit-level reference model (16 clks per bit at DIV=1).
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic [1:0] parity_type = 2'b00;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_error;
  logic       framing_error;
  logic       rx_busy;

  int checks = 0;
  int fails = 0;

  logic [9:0] got_q[$];
  int         long_pulses = 0;
  bit         dv_prev = 1'b0;

  uart_rx #(
    .CLK_FREQ   (1_600_000),
    .BAUD       (100_000),
    .OVERSAMPLE (16),
    .DATA_BITS  (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rx            (rx),
    .parity_type   (parity_type),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .parity_error  (parity_error),
    .framing_error (framing_error),
    .rx_busy       (rx_busy)
  );

  always #5 clk = ~clk;

  // Record every delivered frame and any data_valid lasting more than one clock
  always @(negedge clk) begin
    if (data_valid) got_q.push_back({framing_error, parity_error, data_out});
    if (data_valid && dv_prev) long_pulses++;
    dv_prev = data_valid;
  end

  // Expected {framing_error, parity_error, byte} from counting ones in the frame
  function automatic logic [9:0] model(input logic [7:0] d, input logic [1:0] pt,
                                       input logic pbit, input logic stop);
    int  ones;
    logic pe;
    ones = $countones(d) + int'(pbit);
    case (pt)
      2'b01:   pe = (ones % 2) != 1;
      2'b10:   pe = (ones % 2) != 0;
      default: pe = 1'b0;
    endcase
    return {~stop, pe, d};
  endfunction

  // Drive one frame; pct scales the bit period (100 = 16 clks per bit)
  task automatic send_frame(input logic [7:0] d, input logic [1:0] pt, input logic pbit,
                            input logic stop, input int pct, input bit scramble);
    logic bits[$];
    int   c;
    bits = {};
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pt == 2'b01 || pt == 2'b10) bits.push_back(pbit);
    bits.push_back(stop);
    parity_type = pt;
    c = 0;
    for (int i = 0; i < bits.size(); i++) begin
      rx = bits[i];
      if (scramble && i == 1) parity_type = 2'($urandom);
      while (c < ((i + 1) * 16 * pct + 50) / 100) begin
        @(negedge clk);
        c++;
      end
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    idle(3);
    reset = 1'b0;
    idle(20);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (data_out !== 8'h00)     begin fails++; $display("FAIL reset data_out: got %h want 00", data_out); end
    checks++; if (data_valid !== 1'b0)    begin fails++; $display("FAIL reset data_valid: got %b want 0", data_valid); end
    checks++; if (parity_error !== 1'b0)  begin fails++; $display("FAIL reset parity_error: got %b want 0", parity_error); end
    checks++; if (framing_error !== 1'b0) begin fails++; $display("FAIL reset framing_error: got %b want 0", framing_error); end
    checks++; if (rx_busy !== 1'b0)       begin fails++; $display("FAIL reset rx_busy: got %b want 0", rx_busy); end
    reset = 1'b0;
    idle(20);
    checks++; if (got_q.size() != 0) begin fails++; $display("FAIL reset no_valid: got %0d frames want 0", got_q.size()); end
  endtask

  task automatic test_parity_odd;
    logic [9:0] exp;
    got_q = {};
    exp = model(8'hAF, 2'b01, 1'b1, 1'b1);
    send_frame(8'hAF, 2'b01, 1'b1, 1'b1, 100, 1'b0);
    idle(20);
    checks++; if (got_q.size() != 1) begin fails++; $display("FAIL odd count: got %0d want 1", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== exp) begin fails++; $display("FAIL odd frame: got %h want %h", got_q[0], exp); end
    end
    checks++; if (data_out !== 8'hAF) begin fails++; $display("FAIL odd data_out hold: got %h want af", data_out); end
    checks++; if (long_pulses != 0) begin fails++; $display("FAIL odd pulse width: got %0d long pulses want 0", long_pulses); end
  endtask

  task automatic test_parity_even_error;
    logic [9:0] exp0, exp1;
    got_q = {};
    exp0 = model(8'hA3, 2'b10, 1'b1, 1'b1);
    exp1 = model(8'h55, 2'b00, 1'b0, 1'b1);
    send_frame(8'hA3, 2'b10, 1'b1, 1'b1, 100, 1'b0);
    idle(20);
    checks++; if (parity_error !== exp0[8]) begin fails++; $display("FAIL even parity_error: got %b want %b", parity_error, exp0[8]); end
    send_frame(8'h55, 2'b00, 1'b0, 1'b1, 100, 1'b0);
    idle(20);
    checks++; if (got_q.size() != 2) begin fails++; $display("FAIL even count: got %0d want 2", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== exp0) begin fails++; $display("FAIL even bad frame: got %h want %h", got_q[0], exp0); end
      checks++; if (got_q[1] !== exp1) begin fails++; $display("FAIL even next frame: got %h want %h", got_q[1], exp1); end
    end
  endtask

  task automatic test_break;
    logic [9:0] exp;
    got_q = {};
    exp = model(8'h3C, 2'b00, 1'b0, 1'b0);
    send_frame(8'h3C, 2'b00, 1'b0, 1'b0, 100, 1'b0);
    repeat (40 * 16) @(negedge clk);
    checks++; if (rx_busy !== 1'b1) begin fails++; $display("FAIL break busy held: got %b want 1", rx_busy); end
    checks++; if (got_q.size() != 1) begin fails++; $display("FAIL break count: got %0d want 1", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== exp) begin fails++; $display("FAIL break frame: got %h want %h", got_q[0], exp); end
    end
    idle(8);
    checks++; if (rx_busy !== 1'b0) begin fails++; $display("FAIL break busy release: got %b want 0", rx_busy); end
    checks++; if (got_q.size() != 1) begin fails++; $display("FAIL break retrigger: got %0d frames want 1", got_q.size()); end
  endtask

  task automatic test_glitch;
    got_q = {};
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    checks++; if (rx_busy !== 1'b1) begin fails++; $display("FAIL glitch busy rise: got %b want 1", rx_busy); end
    idle(40);
    checks++; if (rx_busy !== 1'b0) begin fails++; $display("FAIL glitch busy drop: got %b want 0", rx_busy); end
    checks++; if (got_q.size() != 0) begin fails++; $display("FAIL glitch no_valid: got %0d frames want 0", got_q.size()); end
  endtask

  task automatic test_reset_mid_frame;
    logic [9:0] exp;
    got_q = {};
    rx = 1'b0;
    repeat (16) @(negedge clk);
    rx = 1'b1;  // bit0 of 0x81
    repeat (16) @(negedge clk);
    rx = 1'b0;  // bit1
    repeat (8) @(negedge clk);
    checks++; if (rx_busy !== 1'b1) begin fails++; $display("FAIL midreset busy before: got %b want 1", rx_busy); end
    rx = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    checks++; if (rx_busy !== 1'b0)   begin fails++; $display("FAIL midreset busy: got %b want 0", rx_busy); end
    checks++; if (data_out !== 8'h00) begin fails++; $display("FAIL midreset data_out: got %h want 00", data_out); end
    reset = 1'b0;
    idle(40);
    checks++; if (got_q.size() != 0) begin fails++; $display("FAIL midreset no_valid: got %0d frames want 0", got_q.size()); end
    exp = model(8'h7E, 2'b00, 1'b0, 1'b1);
    send_frame(8'h7E, 2'b00, 1'b0, 1'b1, 100, 1'b0);
    idle(20);
    checks++; if (got_q.size() != 1) begin fails++; $display("FAIL midreset next count: got %0d want 1", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== exp) begin fails++; $display("FAIL midreset next frame: got %h want %h", got_q[0], exp); end
    end
  endtask

  task automatic test_back_to_back;
    logic [9:0] exp[2];
    got_q = {};
    exp[0] = model(8'h00, 2'b00, 1'b0, 1'b1);
    exp[1] = model(8'hFF, 2'b00, 1'b0, 1'b1);
    send_frame(8'h00, 2'b00, 1'b0, 1'b1, 103, 1'b0);
    send_frame(8'hFF, 2'b00, 1'b0, 1'b1, 103, 1'b0);
    idle(20);
    checks++; if (got_q.size() != 2) begin fails++; $display("FAIL b2b count: got %0d want 2", got_q.size()); end
    else begin
      for (int i = 0; i < 2; i++) begin
        checks++; if (got_q[i] !== exp[i]) begin fails++; $display("FAIL b2b frame%0d: got %h want %h", i, got_q[i], exp[i]); end
      end
    end
    checks++; if (long_pulses != 0) begin fails++; $display("FAIL b2b pulse width: got %0d long pulses want 0", long_pulses); end
  endtask

  task automatic test_random;
    logic [9:0] exp_q[$];
    logic [7:0] d;
    logic [1:0] pt;
    logic       pb;
    got_q = {};
    exp_q = {};
    for (int n = 0; n < 24; n++) begin
      d  = 8'($urandom);
      pt = 2'($urandom);
      pb = 1'($urandom);
      exp_q.push_back(model(d, pt, pb, 1'b1));
      send_frame(d, pt, pb, 1'b1, int'($urandom_range(97, 103)), 1'b1);
      idle(int'($urandom_range(0, 2)) * 16);
    end
    idle(20);
    checks++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL random count: got %0d want %0d", got_q.size(), exp_q.size()); end
    else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL random frame%0d: got %h want %h", i, got_q[i], exp_q[i]); end
      end
    end
    checks++; if (long_pulses != 0) begin fails++; $display("FAIL random pulse width: got %0d long pulses want 0", long_pulses); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_parity_odd();
    test_parity_even_error();
    test_break();
    test_glitch();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
